otter_intr_ctrl: RTL

Interrupt controller that generates the INTR request consumed by the multicycle OTTER control FSM and retires it on that FSM's INT_TAKEN pulse. It collects N_SRC asynchronous external interrupt lines, synchronizes them, and latches pending events per line. It applies per-source enables and the CSR global enable, then presents a single registered INTR plus the ID of the highest-priority source. After an interrupt is taken, further requests are blocked until the handler returns (MRET).

---
 rtl/otter_intr_ctrl.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/otter_intr_ctrl.sv
// otter_intr_ctrl
// Interrupt controller for the multicycle OTTER core. Raw interrupt lines are
// synchronized, latched into a pending vector (edge or level per source),
// qualified by the enable register and the CSR global enable, and presented
// as a registered INTR request together with the ID of the winning source.
// Once the control FSM takes the interrupt, new requests are blocked until
// the handler executes MRET.
//
// Ports:
//   CLK        system clock, rising edge
//   RST        asynchronous active-high reset
//   IRQ_IN     raw asynchronous interrupt lines
//   EDGE_MODE  per-source mode: 1 = rising-edge latched, 0 = level
//   MASK_WR    enable register write strobe
//   MASK_DIN   enable register write data
//   MIE        global interrupt enable from the CSR file
//   INT_TAKEN  one-cycle pulse when the control FSM enters its interrupt state
//   MRET       one-cycle pulse when the handler returns
//   INTR       registered interrupt request
//   CAUSE      ID of the source being requested or serviced
//   PENDING    pending vector (mip readback)
//   ENABLE     enable register
module otter_intr_ctrl #(
   parameter int N_SRC       = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic [N_SRC-1:0]           IRQ_IN,
   input  logic [N_SRC-1:0]           EDGE_MODE,
   input  logic                       MASK_WR,
   input  logic [N_SRC-1:0]           MASK_DIN,
   input  logic                       MIE,
   input  logic                       INT_TAKEN,
   input  logic                       MRET,
   output logic                       INTR,
   output logic [$clog2(N_SRC)-1:0]   CAUSE,
   output logic [N_SRC-1:0]           PENDING,
   output logic [N_SRC-1:0]           ENABLE
);

   localparam int CW = $clog2(N_SRC);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_SERVICE
   } state_t;

   // sync_reg[SYNC_STAGES-1] is the fully synchronized sample of each line
   logic [SYNC_STAGES-1:0][N_SRC-1:0] sync_reg;
   logic [N_SRC-1:0]                  prev_reg;
   logic [N_SRC-1:0]                  pending_reg;
   logic [N_SRC-1:0]                  enable_reg;
   logic                              intr_reg;
   logic [CW-1:0]                     cause_reg;
   state_t                            state_reg;

   logic [N_SRC-1:0]                  sync_s;
   logic [N_SRC-1:0]                  rise;
   logic [N_SRC-1:0]                  act;
   logic [CW-1:0]                     winner;
   logic                              take_now;

   assign sync_s   = sync_reg[SYNC_STAGES-1];
   assign rise     = sync_s & ~prev_reg;
   assign act      = pending_reg & enable_reg;
   // Only a take while actually requesting retires an event
   assign take_now = (state_reg == ST_REQ) && INT_TAKEN;

   // Lowest set index wins: scan downward so the last hit is the smallest
   always_comb begin
      winner = '0;
      for (int i = N_SRC - 1; i >= 0; i--) begin
         if (act[i]) begin
            winner = CW'(i);
         end
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         sync_reg <= '0;
         prev_reg <= '0;
      end else begin
         sync_reg <= {sync_reg[SYNC_STAGES-2:0], IRQ_IN};
         prev_reg <= sync_s;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         enable_reg <= '0;
      end else if (MASK_WR) begin
         enable_reg <= MASK_DIN;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < N_SRC; gi++) begin : g_pending
         logic clear_hit;
         // CAUSE is frozen at the take, so it names the retired source
         assign clear_hit = take_now && (cause_reg == CW'(gi));

         always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
               pending_reg[gi] <= 1'b0;
            end else if (!EDGE_MODE[gi]) begin
               pending_reg[gi] <= sync_s[gi];
            end else if (rise[gi]) begin
               // a new edge in the same cycle as the take must not be lost
               pending_reg[gi] <= 1'b1;
            end else if (clear_hit) begin
               pending_reg[gi] <= 1'b0;
            end
         end
      end
   endgenerate

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_reg <= ST_IDLE;
         intr_reg  <= 1'b0;
         cause_reg <= '0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (MIE && (act != '0)) begin
                  intr_reg  <= 1'b1;
                  cause_reg <= winner;
                  state_reg <= ST_REQ;
               end
            end
            ST_REQ: begin
               if (INT_TAKEN) begin
                  intr_reg  <= 1'b0;
                  state_reg <= ST_SERVICE;
               end else if (!MIE || (act == '0)) begin
                  intr_reg  <= 1'b0;
                  state_reg <= ST_IDLE;
               end else begin
                  cause_reg <= winner;
               end
            end
            ST_SERVICE: begin
               intr_reg <= 1'b0;
               if (MRET) begin
                  state_reg <= ST_IDLE;
               end
            end
            default: begin
               intr_reg  <= 1'b0;
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   assign INTR    = intr_reg;
   assign CAUSE   = cause_reg;
   assign PENDING = pending_reg;
   assign ENABLE  = enable_reg;

endmodule
